// File: rtl/dmem_arb_pkg.sv
// Shared types for the DMem arbiter: FSM state encoding and owner constants.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester/DMem bundle for dmem_arbiter. The slave modport is the arbiter's
// view; the master modport is the requester and memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_a;
    logic                  req_b;
    logic                  we_a;
    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wdata_a;
    logic [DATA_WIDTH-1:0] wdata_b;
    logic                  gnt_a;
    logic                  gnt_b;
    logic                  ack_a;
    logic                  ack_b;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
        output gnt_a, gnt_b, ack_a, ack_b, rdata, mem_addr, mem_wdata, mem_write
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
        input  gnt_a, gnt_b, ack_a, ack_b, rdata, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way picker. Round-robin on ties by default;
// define DMEM_ARB_FIXED_PRIO_EN to make port A always win ties.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_owner
);
    always_comb begin
        grant_valid = req_a | req_b;
        grant_owner = OWNER_A;
        if (req_a && req_b) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            grant_owner = OWNER_A;
`else
            // The port that did not win last time takes the tie.
            grant_owner = (last_grant == OWNER_A) ? OWNER_B : OWNER_A;
`endif
        end else if (req_b) begin
            grant_owner = OWNER_B;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port DMem between port A (CPU) and port B (debug).
// IDLE -> ACCESS -> DONE sequencer; tie policy selected by DMEM_ARB_FIXED_PRIO_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    dmem_arbiter_if.slave bus
);
    arb_state_e            state_q, state_d;
    logic                  owner_q;
    logic                  last_grant_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  grant_valid;
    logic                  grant_owner;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_arb2 u_arb (
        .req_a       (bus.req_a),
        .req_b       (bus.req_b),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign sel_we    = (owner_q == OWNER_B) ? bus.we_b    : bus.we_a;
    assign sel_addr  = (owner_q == OWNER_B) ? bus.addr_b  : bus.addr_a;
    assign sel_wdata = (owner_q == OWNER_B) ? bus.wdata_b : bus.wdata_a;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Requests are only looked at in IDLE; ACCESS and DONE always last one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owner_q      <= OWNER_A;
            last_grant_q <= OWNER_B;
            rdata_q      <= '0;
        end else begin
            if (state_q == IDLE && grant_valid) begin
                owner_q      <= grant_owner;
                last_grant_q <= grant_owner;
            end
            if (state_q == ACCESS && !sel_we) rdata_q <= bus.mem_rdata;
        end
    end

    // Memory bus is zero outside ACCESS, so an async reset kills mem_write at once.
    always_comb begin
        bus.gnt_a     = (state_q != IDLE) && (owner_q == OWNER_A);
        bus.gnt_b     = (state_q != IDLE) && (owner_q == OWNER_B);
        bus.ack_a     = (state_q == DONE) && (owner_q == OWNER_A);
        bus.ack_b     = (state_q == DONE) && (owner_q == OWNER_B);
        bus.rdata     = rdata_q;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state_q == ACCESS) begin
            bus.mem_write = sel_we;
            bus.mem_addr  = sel_addr;
            bus.mem_wdata = sel_wdata;
        end
    end
endmodule
